// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions: op encodings, field constants and sequencer states.
package gf_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_DIV = 2'b01,
        OP_INV = 2'b10,
        OP_LOG = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOGA,
        S_LOGB,
        S_EXP,
        S_RESP
    } state_e;

    localparam logic [8:0] GF_ORDER = 9'd255;
    localparam logic [8:0] GF_POLY  = 9'h11D;

endpackage

// File: rtl/gf_arith_seq_if.sv
// Request/response bundle between the RS-codec datapath and the GF arithmetic unit.
interface gf_arith_seq_if;
    import gf_pkg::*;

    logic       in_valid;
    logic       in_ready;
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       err;
    logic       busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, err, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, err, busy
    );

endinterface

// File: rtl/gf_antilog.sv
// Combinational antilog table for GF(2^8), poly 0x11D, generator 0x02: val = 2^exp.
module gf_antilog (
    input  logic [7:0] exp_i,
    output logic [7:0] val_o
);

    // Exponent 255 aliases 0 in the field and is never presented; it maps to 0.
    always_comb begin
        case (exp_i)
            8'd0:   val_o = 8'h01; 8'd1:   val_o = 8'h02; 8'd2:   val_o = 8'h04; 8'd3:   val_o = 8'h08;
            8'd4:   val_o = 8'h10; 8'd5:   val_o = 8'h20; 8'd6:   val_o = 8'h40; 8'd7:   val_o = 8'h80;
            8'd8:   val_o = 8'h1D; 8'd9:   val_o = 8'h3A; 8'd10:  val_o = 8'h74; 8'd11:  val_o = 8'hE8;
            8'd12:  val_o = 8'hCD; 8'd13:  val_o = 8'h87; 8'd14:  val_o = 8'h13; 8'd15:  val_o = 8'h26;
            8'd16:  val_o = 8'h4C; 8'd17:  val_o = 8'h98; 8'd18:  val_o = 8'h2D; 8'd19:  val_o = 8'h5A;
            8'd20:  val_o = 8'hB4; 8'd21:  val_o = 8'h75; 8'd22:  val_o = 8'hEA; 8'd23:  val_o = 8'hC9;
            8'd24:  val_o = 8'h8F; 8'd25:  val_o = 8'h03; 8'd26:  val_o = 8'h06; 8'd27:  val_o = 8'h0C;
            8'd28:  val_o = 8'h18; 8'd29:  val_o = 8'h30; 8'd30:  val_o = 8'h60; 8'd31:  val_o = 8'hC0;
            8'd32:  val_o = 8'h9D; 8'd33:  val_o = 8'h27; 8'd34:  val_o = 8'h4E; 8'd35:  val_o = 8'h9C;
            8'd36:  val_o = 8'h25; 8'd37:  val_o = 8'h4A; 8'd38:  val_o = 8'h94; 8'd39:  val_o = 8'h35;
            8'd40:  val_o = 8'h6A; 8'd41:  val_o = 8'hD4; 8'd42:  val_o = 8'hB5; 8'd43:  val_o = 8'h77;
            8'd44:  val_o = 8'hEE; 8'd45:  val_o = 8'hC1; 8'd46:  val_o = 8'h9F; 8'd47:  val_o = 8'h23;
            8'd48:  val_o = 8'h46; 8'd49:  val_o = 8'h8C; 8'd50:  val_o = 8'h05; 8'd51:  val_o = 8'h0A;
            8'd52:  val_o = 8'h14; 8'd53:  val_o = 8'h28; 8'd54:  val_o = 8'h50; 8'd55:  val_o = 8'hA0;
            8'd56:  val_o = 8'h5D; 8'd57:  val_o = 8'hBA; 8'd58:  val_o = 8'h69; 8'd59:  val_o = 8'hD2;
            8'd60:  val_o = 8'hB9; 8'd61:  val_o = 8'h6F; 8'd62:  val_o = 8'hDE; 8'd63:  val_o = 8'hA1;
            8'd64:  val_o = 8'h5F; 8'd65:  val_o = 8'hBE; 8'd66:  val_o = 8'h61; 8'd67:  val_o = 8'hC2;
            8'd68:  val_o = 8'h99; 8'd69:  val_o = 8'h2F; 8'd70:  val_o = 8'h5E; 8'd71:  val_o = 8'hBC;
            8'd72:  val_o = 8'h65; 8'd73:  val_o = 8'hCA; 8'd74:  val_o = 8'h89; 8'd75:  val_o = 8'h0F;
            8'd76:  val_o = 8'h1E; 8'd77:  val_o = 8'h3C; 8'd78:  val_o = 8'h78; 8'd79:  val_o = 8'hF0;
            8'd80:  val_o = 8'hFD; 8'd81:  val_o = 8'hE7; 8'd82:  val_o = 8'hD3; 8'd83:  val_o = 8'hBB;
            8'd84:  val_o = 8'h6B; 8'd85:  val_o = 8'hD6; 8'd86:  val_o = 8'hB1; 8'd87:  val_o = 8'h7F;
            8'd88:  val_o = 8'hFE; 8'd89:  val_o = 8'hE1; 8'd90:  val_o = 8'hDF; 8'd91:  val_o = 8'hA3;
            8'd92:  val_o = 8'h5B; 8'd93:  val_o = 8'hB6; 8'd94:  val_o = 8'h71; 8'd95:  val_o = 8'hE2;
            8'd96:  val_o = 8'hD9; 8'd97:  val_o = 8'hAF; 8'd98:  val_o = 8'h43; 8'd99:  val_o = 8'h86;
            8'd100: val_o = 8'h11; 8'd101: val_o = 8'h22; 8'd102: val_o = 8'h44; 8'd103: val_o = 8'h88;
            8'd104: val_o = 8'h0D; 8'd105: val_o = 8'h1A; 8'd106: val_o = 8'h34; 8'd107: val_o = 8'h68;
            8'd108: val_o = 8'hD0; 8'd109: val_o = 8'hBD; 8'd110: val_o = 8'h67; 8'd111: val_o = 8'hCE;
            8'd112: val_o = 8'h81; 8'd113: val_o = 8'h1F; 8'd114: val_o = 8'h3E; 8'd115: val_o = 8'h7C;
            8'd116: val_o = 8'hF8; 8'd117: val_o = 8'hED; 8'd118: val_o = 8'hC7; 8'd119: val_o = 8'h93;
            8'd120: val_o = 8'h3B; 8'd121: val_o = 8'h76; 8'd122: val_o = 8'hEC; 8'd123: val_o = 8'hC5;
            8'd124: val_o = 8'h97; 8'd125: val_o = 8'h33; 8'd126: val_o = 8'h66; 8'd127: val_o = 8'hCC;
            8'd128: val_o = 8'h85; 8'd129: val_o = 8'h17; 8'd130: val_o = 8'h2E; 8'd131: val_o = 8'h5C;
            8'd132: val_o = 8'hB8; 8'd133: val_o = 8'h6D; 8'd134: val_o = 8'hDA; 8'd135: val_o = 8'hA9;
            8'd136: val_o = 8'h4F; 8'd137: val_o = 8'h9E; 8'd138: val_o = 8'h21; 8'd139: val_o = 8'h42;
            8'd140: val_o = 8'h84; 8'd141: val_o = 8'h15; 8'd142: val_o = 8'h2A; 8'd143: val_o = 8'h54;
            8'd144: val_o = 8'hA8; 8'd145: val_o = 8'h4D; 8'd146: val_o = 8'h9A; 8'd147: val_o = 8'h29;
            8'd148: val_o = 8'h52; 8'd149: val_o = 8'hA4; 8'd150: val_o = 8'h55; 8'd151: val_o = 8'hAA;
            8'd152: val_o = 8'h49; 8'd153: val_o = 8'h92; 8'd154: val_o = 8'h39; 8'd155: val_o = 8'h72;
            8'd156: val_o = 8'hE4; 8'd157: val_o = 8'hD5; 8'd158: val_o = 8'hB7; 8'd159: val_o = 8'h73;
            8'd160: val_o = 8'hE6; 8'd161: val_o = 8'hD1; 8'd162: val_o = 8'hBF; 8'd163: val_o = 8'h63;
            8'd164: val_o = 8'hC6; 8'd165: val_o = 8'h91; 8'd166: val_o = 8'h3F; 8'd167: val_o = 8'h7E;
            8'd168: val_o = 8'hFC; 8'd169: val_o = 8'hE5; 8'd170: val_o = 8'hD7; 8'd171: val_o = 8'hB3;
            8'd172: val_o = 8'h7B; 8'd173: val_o = 8'hF6; 8'd174: val_o = 8'hF1; 8'd175: val_o = 8'hFF;
            8'd176: val_o = 8'hE3; 8'd177: val_o = 8'hDB; 8'd178: val_o = 8'hAB; 8'd179: val_o = 8'h4B;
            8'd180: val_o = 8'h96; 8'd181: val_o = 8'h31; 8'd182: val_o = 8'h62; 8'd183: val_o = 8'hC4;
            8'd184: val_o = 8'h95; 8'd185: val_o = 8'h37; 8'd186: val_o = 8'h6E; 8'd187: val_o = 8'hDC;
            8'd188: val_o = 8'hA5; 8'd189: val_o = 8'h57; 8'd190: val_o = 8'hAE; 8'd191: val_o = 8'h41;
            8'd192: val_o = 8'h82; 8'd193: val_o = 8'h19; 8'd194: val_o = 8'h32; 8'd195: val_o = 8'h64;
            8'd196: val_o = 8'hC8; 8'd197: val_o = 8'h8D; 8'd198: val_o = 8'h07; 8'd199: val_o = 8'h0E;
            8'd200: val_o = 8'h1C; 8'd201: val_o = 8'h38; 8'd202: val_o = 8'h70; 8'd203: val_o = 8'hE0;
            8'd204: val_o = 8'hDD; 8'd205: val_o = 8'hA7; 8'd206: val_o = 8'h53; 8'd207: val_o = 8'hA6;
            8'd208: val_o = 8'h51; 8'd209: val_o = 8'hA2; 8'd210: val_o = 8'h59; 8'd211: val_o = 8'hB2;
            8'd212: val_o = 8'h79; 8'd213: val_o = 8'hF2; 8'd214: val_o = 8'hF9; 8'd215: val_o = 8'hEF;
            8'd216: val_o = 8'hC3; 8'd217: val_o = 8'h9B; 8'd218: val_o = 8'h2B; 8'd219: val_o = 8'h56;
            8'd220: val_o = 8'hAC; 8'd221: val_o = 8'h45; 8'd222: val_o = 8'h8A; 8'd223: val_o = 8'h09;
            8'd224: val_o = 8'h12; 8'd225: val_o = 8'h24; 8'd226: val_o = 8'h48; 8'd227: val_o = 8'h90;
            8'd228: val_o = 8'h3D; 8'd229: val_o = 8'h7A; 8'd230: val_o = 8'hF4; 8'd231: val_o = 8'hF5;
            8'd232: val_o = 8'hF7; 8'd233: val_o = 8'hF3; 8'd234: val_o = 8'hFB; 8'd235: val_o = 8'hEB;
            8'd236: val_o = 8'hCB; 8'd237: val_o = 8'h8B; 8'd238: val_o = 8'h0B; 8'd239: val_o = 8'h16;
            8'd240: val_o = 8'h2C; 8'd241: val_o = 8'h58; 8'd242: val_o = 8'hB0; 8'd243: val_o = 8'h7D;
            8'd244: val_o = 8'hFA; 8'd245: val_o = 8'hE9; 8'd246: val_o = 8'hCF; 8'd247: val_o = 8'h83;
            8'd248: val_o = 8'h1B; 8'd249: val_o = 8'h36; 8'd250: val_o = 8'h6C; 8'd251: val_o = 8'hD8;
            8'd252: val_o = 8'hAD; 8'd253: val_o = 8'h47; 8'd254: val_o = 8'h8E;
            default: val_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/gf_arith_seq.sv
// Sequenced GF(2^8) multiply/divide/inverse/log unit. Operand logs are read one per
// cycle from a shared external log table; exponents map back through a local antilog table.
module gf_arith_seq
    import gf_pkg::*;
#(
    parameter int FAST_UNARY = 1,
    parameter int W          = 8
) (
    input  logic          clk,
    input  logic          rst,
    gf_arith_seq_if.slave bus,
    output logic [7:0]    log_addr,
    input  logic [7:0]    log_data
);

    // The antilog table is hard-coded for 8-bit symbols over 0x11D.
    if (W != 8 || GF_POLY != 9'h11D) begin : g_bad_cfg
        $error("gf_arith_seq: only W=8 over the 0x11D field is supported");
    end

    state_e            state_q, state_d;
    op_e               op_q;
    logic [7:0]        a_q, b_q, la_q, lb_q, result_q, result_d;
    logic              err_q, err_d;
    logic [8:0]        sum_w, e_w;
    logic signed [9:0] diff_w;
    logic              zero_res, zero_err, unary_skip;
    logic [7:0]        alog;

    gf_antilog u_antilog (
        .exp_i (e_w[7:0]),
        .val_o (alog)
    );

    assign unary_skip = (FAST_UNARY != 0) && (op_q == OP_INV || op_q == OP_LOG);

    always_comb begin
        state_d  = state_q;
        log_addr = 8'd0;
        case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_LOGA;
            S_LOGA: begin
                log_addr = a_q;
                state_d  = unary_skip ? S_EXP : S_LOGB;
            end
            S_LOGB: begin
                log_addr = b_q;
                state_d  = S_EXP;
            end
            S_EXP:  state_d = S_RESP;
            S_RESP: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Exponent arithmetic is mod 255; any zero operand bypasses the log domain entirely.
    always_comb begin
        sum_w    = {1'b0, la_q} + {1'b0, lb_q};
        diff_w   = $signed({2'b00, la_q}) - $signed({2'b00, lb_q});
        e_w      = {1'b0, la_q};
        zero_res = (a_q == 8'd0);
        zero_err = (a_q == 8'd0);
        case (op_q)
            OP_MUL: begin
                e_w      = (sum_w >= GF_ORDER) ? sum_w - GF_ORDER : sum_w;
                zero_res = (a_q == 8'd0) || (b_q == 8'd0);
                zero_err = 1'b0;
            end
            OP_DIV: begin
                e_w      = (diff_w < 0) ? 9'(diff_w + 10'sd255) : 9'(diff_w);
                zero_res = (a_q == 8'd0) || (b_q == 8'd0);
                zero_err = (b_q == 8'd0);
            end
            OP_INV: e_w = (la_q == 8'd0) ? 9'd0 : GF_ORDER - {1'b0, la_q};
            default: ;
        endcase
        if (zero_res)              result_d = 8'd0;
        else if (op_q == OP_LOG)   result_d = la_q;
        else                       result_d = alog;
        err_d = zero_err;
    end

    assert property (@(posedge clk) disable iff (rst)
        (state_q == S_EXP && !zero_res && op_q != OP_LOG) |-> (e_w < GF_ORDER));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            la_q     <= 8'd0;
            lb_q     <= 8'd0;
            result_q <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.in_valid) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
            if (state_q == S_LOGA) la_q <= log_data;
            if (state_q == S_LOGB) lb_q <= log_data;
            if (state_q == S_EXP) begin
                result_q <= result_d;
                err_q    <= err_d;
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_RESP);
    assign bus.result    = result_q;
    assign bus.err       = err_q;

endmodule
